// File: rtl/tsar_pkg.sv
// Shared definitions for the time-domain SAR ADC readout: FSM encoding,
// result width and default timing constants.
package tsar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_CAPTURE = 2'd3
  } tsar_state_e;

  localparam int TSAR_BITS            = 8;
  localparam int TSAR_SAMPLE_DEFAULT  = 4;
  localparam int TSAR_TIMEOUT_DEFAULT = 64;
  localparam int TSAR_SYNC_DEFAULT    = 2;

endpackage

// File: rtl/tsar_sync.sv
// Multi-stage single-bit synchronizer for the asynchronous FINAL flag.
module tsar_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift chain; the last stage is the synchronized output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/tsar_readout.sv
// Sample/convert sequencer and result register for the 8-bit time-domain
// SAR ADC, with valid/ready readout and sticky overrun/timeout flags.
module tsar_readout
  import tsar_pkg::*;
#(
  parameter int SAMPLE_CYCLES  = TSAR_SAMPLE_DEFAULT,
  parameter int TIMEOUT_CYCLES = TSAR_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = TSAR_SYNC_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 FINAL,
  input  logic [TSAR_BITS-1:0] D,
  output logic                 CKS,
  output logic                 BUSY,
  output logic [TSAR_BITS-1:0] DOUT,
  output logic                 DVALID,
  input  logic                 DREADY,
  output logic                 OVR,
  output logic                 TOUT
);

  localparam int SCW = $clog2(SAMPLE_CYCLES);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  tsar_state_e          state_q;
  logic [SCW-1:0]       scnt_q;
  logic [TCW-1:0]       tcnt_q;
  logic                 cks_q;
  logic                 busy_q;
  logic                 dvalid_q;
  logic                 ovr_q;
  logic                 tout_q;
  logic [TSAR_BITS-1:0] dout_q;

  logic final_s;
  logic load_s;
  logic ovr_set_s;
  logic tout_set_s;

  tsar_sync #(
    .STAGES (SYNC_STAGES)
  ) u_final_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (FINAL),
    .q_o    (final_s)
  );

  // A capture either lands (register free or drained this edge) or overruns.
  assign load_s     = (state_q == ST_CAPTURE) && (!dvalid_q || DREADY);
  assign ovr_set_s  = (state_q == ST_CAPTURE) && dvalid_q && !DREADY;
  assign tout_set_s = (state_q == ST_CONVERT) && !final_s &&
                      (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));

  // Sequencer, counters, result register and sticky flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      cks_q    <= 1'b0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      tout_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cks_q <= 1'b0;
          if (EN) begin
            state_q <= ST_SAMPLE;
            scnt_q  <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (!EN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
            state_q <= ST_CONVERT;
            cks_q   <= 1'b1;
            tcnt_q  <= '0;
          end else begin
            scnt_q  <= scnt_q + SCW'(1);
          end
        end
        ST_CONVERT: begin
          if (final_s) begin
            state_q <= ST_CAPTURE;
          end else if (tout_set_s) begin
            cks_q   <= 1'b0;
            scnt_q  <= '0;
            busy_q  <= EN;
            state_q <= EN ? ST_SAMPLE : ST_IDLE;
          end else begin
            tcnt_q  <= tcnt_q + TCW'(1);
          end
        end
        ST_CAPTURE: begin
          cks_q   <= 1'b0;
          scnt_q  <= '0;
          busy_q  <= EN;
          state_q <= EN ? ST_SAMPLE : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cks_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      if (load_s) begin
        dout_q   <= D;
        dvalid_q <= 1'b1;
      end else if (dvalid_q && DREADY) begin
        dvalid_q <= 1'b0;
      end else begin
        dvalid_q <= dvalid_q;
      end

      // A set on the same edge as CLR takes priority.
      if (ovr_set_s) begin
        ovr_q <= 1'b1;
      end else if (CLR) begin
        ovr_q <= 1'b0;
      end else begin
        ovr_q <= ovr_q;
      end

      if (tout_set_s) begin
        tout_q <= 1'b1;
      end else if (CLR) begin
        tout_q <= 1'b0;
      end else begin
        tout_q <= tout_q;
      end
    end
  end

  assign CKS    = cks_q;
  assign BUSY   = busy_q;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign OVR    = ovr_q;
  assign TOUT   = tout_q;

endmodule

// File: tb/tb_tsar_readout.sv
// Directed self-checking bench for tsar_readout at default parameters.
module tb_tsar_readout;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       CLR;
  logic       FINAL;
  logic [7:0] D;
  logic       CKS;
  logic       BUSY;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       DREADY;
  logic       OVR;
  logic       TOUT;

  int checks_cnt;
  int fail_cnt;

  tsar_readout dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .CLR    (CLR),
    .FINAL  (FINAL),
    .D      (D),
    .CKS    (CKS),
    .BUSY   (BUSY),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .OVR    (OVR),
    .TOUT   (TOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Wait for CKS high, optionally drop EN, fire FINAL after dly cycles,
  // and expect the capture edge exactly four edges after FINAL.
  task automatic run_conv(input logic [7:0] d, input int dly, input bit rdy_cap, input bit drop_en);
    int n;
    n = 0;
    while (!CKS && n < 40) begin
      tick();
      n++;
    end
    check_val("cks_rise", {31'd0, CKS}, 32'd1);
    if (drop_en) EN = 1'b0;
    repeat (dly) tick();
    FINAL = 1'b1;
    D     = d;
    repeat (3) tick();
    check_val("cks_before_cap", {31'd0, CKS}, 32'd1);
    if (rdy_cap) DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    FINAL  = 1'b0;
    check_val("cks_after_cap", {31'd0, CKS}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    checks_cnt = 0;
    fail_cnt   = 0;
    RST_N  = 1'b0;
    EN     = 1'b0;
    CLR    = 1'b0;
    FINAL  = 1'b0;
    D      = 8'h00;
    DREADY = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    check_val("rst_cks",    {31'd0, CKS},    32'd0);
    check_val("rst_busy",   {31'd0, BUSY},   32'd0);
    check_val("rst_dout",   {24'd0, DOUT},   32'h00);
    check_val("rst_dvalid", {31'd0, DVALID}, 32'd0);
    check_val("rst_ovr",    {31'd0, OVR},    32'd0);
    check_val("rst_tout",   {31'd0, TOUT},   32'd0);
    RST_N = 1'b1;
    tick();

    // Basic conversion: CKS low exactly four cycles, then A5 captured
    EN = 1'b1;
    tick();
    check_val("t1_busy", {31'd0, BUSY}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_val("t1_cks_low", {31'd0, CKS}, 32'd0);
      tick();
    end
    check_val("t1_cks_high", {31'd0, CKS}, 32'd1);
    run_conv(8'hA5, 10, 1'b0, 1'b0);
    check_val("t1_dvalid", {31'd0, DVALID}, 32'd1);
    check_val("t1_dout",   {24'd0, DOUT},   32'hA5);
    check_val("t1_busy2",  {31'd0, BUSY},   32'd1);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    check_val("t1_consumed", {31'd0, DVALID}, 32'd0);
    check_val("t1_dout_keep", {24'd0, DOUT}, 32'hA5);

    // Overrun: second result dropped while first is pending
    run_conv(8'h3C, 5, 1'b0, 1'b0);
    check_val("t2_dvalid1", {31'd0, DVALID}, 32'd1);
    check_val("t2_dout1",   {24'd0, DOUT},   32'h3C);
    check_val("t2_ovr1",    {31'd0, OVR},    32'd0);
    run_conv(8'hC3, 5, 1'b0, 1'b0);
    check_val("t2_dout2",   {24'd0, DOUT},   32'h3C);
    check_val("t2_ovr2",    {31'd0, OVR},    32'd1);
    check_val("t2_dvalid2", {31'd0, DVALID}, 32'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_val("t2_ovr_clr", {31'd0, OVR},    32'd0);
    check_val("t2_dvalid3", {31'd0, DVALID}, 32'd1);

    // Ready on the capture edge: new data replaces, no overrun
    run_conv(8'hC3, 5, 1'b1, 1'b0);
    check_val("t3_dvalid", {31'd0, DVALID}, 32'd1);
    check_val("t3_dout",   {24'd0, DOUT},   32'hC3);
    check_val("t3_ovr",    {31'd0, OVR},    32'd0);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    check_val("t3_consumed", {31'd0, DVALID}, 32'd0);

    // Timeout: CKS high for 64 cycles, no result, SAMPLE restarts
    n = 0;
    while (!CKS && n < 40) begin
      tick();
      n++;
    end
    check_val("t4_cks_rise", {31'd0, CKS}, 32'd1);
    cnt = 0;
    while (CKS && cnt < 100) begin
      tick();
      cnt++;
    end
    check_val("t4_conv_len", cnt, 32'd64);
    check_val("t4_tout",     {31'd0, TOUT},   32'd1);
    check_val("t4_dvalid",   {31'd0, DVALID}, 32'd0);
    check_val("t4_busy",     {31'd0, BUSY},   32'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_val("t4_tout_clr", {31'd0, TOUT}, 32'd0);
    tick();
    tick();
    check_val("t4_cks_low",  {31'd0, CKS}, 32'd0);
    tick();
    check_val("t4_cks_high", {31'd0, CKS}, 32'd1);

    // Reset mid-CONVERT: CKS drops asynchronously
    tick();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    check_val("t5_cks_async", {31'd0, CKS}, 32'd0);
    check_val("t5_busy",      {31'd0, BUSY}, 32'd0);
    check_val("t5_dout",      {24'd0, DOUT}, 32'h00);
    @(negedge CLK);
    check_val("t5_dvalid", {31'd0, DVALID}, 32'd0);
    check_val("t5_cks",    {31'd0, CKS},    32'd0);
    RST_N = 1'b1;
    run_conv(8'h5A, 3, 1'b0, 1'b0);
    check_val("t5_dvalid2", {31'd0, DVALID}, 32'd1);
    check_val("t5_dout2",   {24'd0, DOUT},   32'h5A);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;

    // EN dropped during CONVERT: conversion completes, then IDLE
    run_conv(8'h96, 2, 1'b0, 1'b1);
    check_val("t6_dvalid", {31'd0, DVALID}, 32'd1);
    check_val("t6_dout",   {24'd0, DOUT},   32'h96);
    check_val("t6_busy",   {31'd0, BUSY},   32'd0);
    repeat (6) tick();
    check_val("t6_idle_busy", {31'd0, BUSY}, 32'd0);
    check_val("t6_idle_cks",  {31'd0, CKS},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
